// File: rtl/fifo_pkg.sv
// fifo_pkg
// Types, constants and helper functions shared by the FIFO top level and its
// storage sub-module.
//   fifo_op_e  : classifies one clock cycle by which accesses were accepted.
//                The occupancy counter update is driven by this value.
//   RST_*      : values loaded into the control registers while rst is low.
//   fifo_cw()  : occupancy counter width for a given depth. The counter must
//                reach DEPTH itself, so it is one bit wider than a pointer.
//   is_pow2()  : used by the elaboration-time parameter checks.
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,  // no access accepted
    OP_WR   = 2'b01,  // write only
    OP_RD   = 2'b10,  // read only
    OP_RW   = 2'b11   // write and read in the same cycle
  } fifo_op_e;

  // Reset values for the control registers.
  localparam logic RST_FLAG      = 1'b0;  // overflow, underflow, dout_valid
  localparam logic RST_DOUT_ZERO = 1'b1;  // force dout to zero after reset

  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Storage array for sync_fifo_param: one write port and one synchronous read
// port. There is no reset, so synthesis can map it onto block or distributed
// RAM.
//
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata keeps its value while re is low
//   raddr  in   read address
//   rdata  out  registered read data, valid one cycle after re
//
// The read and the write to the same address in the same cycle return the
// OLD contents (read-first). The FIFO relies on this when it is full and
// both accesses are accepted: wr_ptr equals rd_ptr in that case.
module fifo_ram #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both updates live in one process. Non-blocking semantics give the read
  // the value stored before this edge's write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock FIFO with parametrised width and depth. It has programmable
// almost-full and almost-empty thresholds and sticky overflow/underflow
// flags.
//
// Parameters:
//   WIDTH      data word width (>= 1)
//   DEPTH      number of entries (power of two, >= 4)
//   AF_THRESH  almost_full  when counter >= AF_THRESH
//   AE_THRESH  almost_empty when counter <= AE_THRESH
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   w_en, din     in   write request and its data
//   r_en          in   read request
//   dout          out  read data, one cycle after an accepted r_en
//   dout_valid    out  one-cycle strobe, high when dout carries new data
//   full, empty, half_full, almost_full, almost_empty
//                 out  compares of the registered occupancy
//   counter       out  occupancy, 0..DEPTH
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
//   err_clr       in   synchronous clear of both sticky flags. A new error in
//                      the same cycle takes priority over the clear.
//
// Acceptance is decided from registered state only. A write is accepted
// when the FIFO is not full, or when it is full and a read happens in the
// same cycle. A read is accepted only when the FIFO is not empty, so it
// never returns data written in the same cycle.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [WIDTH-1:0]          din,
  input  logic                      r_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      half_full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [fifo_cw(DEPTH)-1:0] counter,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cw(DEPTH);

  // Thresholds sized to the counter so the compares need no widening.
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // ---------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("sync_fifo_param: WIDTH must be >= 1");
    end
    if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH)))
    begin : g_bad_thresh
      $error("sync_fifo_param: need 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;
  logic          dvalid_q, dvalid_d;
  // The RAM read register has no reset. This flag masks dout to zero from
  // reset until the first accepted read loads real data.
  logic          dout_zero_q, dout_zero_d;

  logic             wr_acc;
  logic             rd_acc;
  fifo_op_e         op;
  logic [WIDTH-1:0] ram_rdata;

  // ---------------------------------------------------------------------
  // Status flags: compares of the registered counter
  // ---------------------------------------------------------------------
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign half_full    = (count_q >= HALF_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // When full, a write is still taken if a read frees the slot in the same
  // cycle. That read is always accepted, because full implies not empty.
  assign wr_acc = w_en & (~full | r_en);
  assign rd_acc = r_en & ~empty;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    op = OP_IDLE;
    unique case ({rd_acc, wr_acc})
      2'b01:   op = OP_WR;
      2'b10:   op = OP_RD;
      2'b11:   op = OP_RW;
      default: op = OP_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dvalid_d    = rd_acc;
    dout_zero_d = dout_zero_q & ~rd_acc;

    // Pointers are exactly AW bits, so they wrap from DEPTH-1 to 0 on
    // overflow of the addition.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case (op)
      OP_WR:   count_d = count_q + CW'(1);
      OP_RD:   count_d = count_q - CW'(1);
      default: count_d = count_q;  // idle, or one in and one out
    endcase

    // The clear is applied first, so a same-cycle error re-sets the flag.
    ovf_d = err_clr ? 1'b0 : ovf_q;
    udf_d = err_clr ? 1'b0 : udf_q;
    if (w_en && !wr_acc) begin
      ovf_d = 1'b1;
    end
    if (r_en && !rd_acc) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= RST_FLAG;
      udf_q       <= RST_FLAG;
      dvalid_q    <= RST_FLAG;
      dout_zero_q <= RST_DOUT_ZERO;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      dvalid_q    <= dvalid_d;
      dout_zero_q <= dout_zero_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  // The RAM read register only loads on an accepted read. This gives the
  // one-cycle read latency, and dout holds its value between reads.
  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign dout       = dout_zero_q ? '0 : ram_rdata;
  assign dout_valid = dvalid_q;
  assign counter    = count_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en, r_en, err_clr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dout_valid, full, empty, half_full, almost_full, almost_empty;
  logic [5:0]  counter;
  logic        overflow, underflow;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH(16), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4)
  ) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .half_full(half_full), .almost_full(almost_full),
    .almost_empty(almost_empty), .counter(counter),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  typedef struct {
    logic        w, r, clr;
    logic [15:0] din;
    int          cnt;
    logic        dv, ovf, udf;
    logic        chk_d;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Status flags expected for a given occupancy, thresholds 28 / 4, depth 32.
  task automatic chk_flags(input string tag, input int cnt);
    chk({tag, ".counter"},      32'(counter),      32'(cnt));
    chk({tag, ".full"},         32'(full),         32'(cnt == 32));
    chk({tag, ".empty"},        32'(empty),        32'(cnt == 0));
    chk({tag, ".half_full"},    32'(half_full),    32'(cnt >= 16));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(cnt >= 28));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 4));
  endtask

  task automatic add(input logic w, input logic r, input logic clr,
                     input logic [15:0] d, input int cnt, input logic dv,
                     input logic ovf, input logic udf, input logic chk_d,
                     input logic [15:0] exp_d);
    vec_t v;
    v.w = w; v.r = r; v.clr = clr; v.din = d; v.cnt = cnt; v.dv = dv;
    v.ovf = ovf; v.udf = udf; v.chk_d = chk_d; v.dout = exp_d;
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after a rising edge. Outputs are checked
  // 1 time unit after the following rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic clr, input logic [15:0] d);
    w_en = w; r_en = r; err_clr = clr; din = d;
  endtask

  initial begin
    string tag;
    rst = 1'b0;
    drive(0, 0, 0, 16'h0);

    // ---- vector table: plan items 1..3 ----
    for (int i = 0; i < 32; i++)
      add(1, 0, 0, 16'(i + 1), i + 1, 0, 0, 0, 0, 16'h0);
    add(1, 0, 0, 16'hDEAD, 32, 0, 1, 0, 0, 16'h0);            // rejected write
    for (int i = 0; i < 32; i++)
      add(0, 1, 0, 16'h0, 31 - i, 1, 1, 0, 1, 16'(i + 1));
    add(0, 0, 1, 16'h0, 0, 0, 0, 0, 1, 16'h0020);             // err_clr, dout holds
    add(1, 1, 0, 16'h1234, 1, 0, 0, 1, 1, 16'h0020);          // r&w at empty
    add(0, 1, 0, 16'h0, 0, 1, 0, 1, 1, 16'h1234);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset", 0);
    chk("reset.dout", 32'(dout), 32'h0);
    chk("reset.dout_valid", 32'(dout_valid), 32'h0);
    chk("reset.overflow", 32'(overflow), 32'h0);
    chk("reset.underflow", 32'(underflow), 32'h0);
    rst = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].w, vecs[k].r, vecs[k].clr, vecs[k].din);
      step();
      tag = $sformatf("v%0d", k);
      chk_flags(tag, vecs[k].cnt);
      chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(vecs[k].dv));
      chk({tag, ".overflow"}, 32'(overflow), 32'(vecs[k].ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(vecs[k].udf));
      if (vecs[k].chk_d) chk({tag, ".dout"}, 32'(dout), 32'(vecs[k].dout));
      $display("[TB] vec %0d w=%0b r=%0b din=%h -> cnt=%0d dout=%h dv=%0b",
               k, vecs[k].w, vecs[k].r, vecs[k].din, counter, dout, dout_valid);
    end
    drive(0, 0, 1, 16'h0);  // clear the underflow left by item 3
    step();

    // ---- plan item 4: read+write while full ----
    for (int i = 0; i < 32; i++) begin drive(1, 0, 0, 16'(16'h0200 + i)); step(); end
    chk_flags("t4.fill", 32);
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 16'(16'h0100 + k));
      step();
      tag = $sformatf("t4.rw%0d", k);
      chk_flags(tag, 32);
      chk({tag, ".dout"}, 32'(dout), 32'(16'h0200 + k));
      chk({tag, ".overflow"}, 32'(overflow), 32'h0);
      $display("[TB] t4 rw %0d dout=%h cnt=%0d", k, dout, counter);
    end
    for (int k = 0; k < 32; k++) begin
      drive(0, 1, 0, 16'h0);
      step();
      tag = $sformatf("t4.drain%0d", k);
      chk({tag, ".dout"}, 32'(dout), (k < 22) ? 32'(16'h020A + k) : 32'(16'h0100 + k - 22));
      chk({tag, ".counter"}, 32'(counter), 32'(31 - k));
    end

    // ---- plan item 5: streaming at count 8 ----
    for (int i = 0; i < 8; i++) begin drive(1, 0, 0, 16'(16'h0300 + i)); step(); end
    for (int k = 0; k < 100; k++) begin
      drive(1, 1, 0, 16'(16'h0400 + k));
      step();
      tag = $sformatf("t5.s%0d", k);
      chk({tag, ".dout"}, 32'(dout), (k < 8) ? 32'(16'h0300 + k) : 32'(16'h0400 + k - 8));
      chk({tag, ".counter"}, 32'(counter), 32'd8);
      chk({tag, ".dout_valid"}, 32'(dout_valid), 32'h1);
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 0, 16'h0);
      step();
      chk($sformatf("t5.tail%0d.dout", k), 32'(dout), 32'(16'h0400 + 92 + k));
    end
    chk_flags("t5.end", 0);
    $display("[TB] t5 streaming done, cnt=%0d", counter);

    // ---- plan item 6: error clear vs new error, then async reset ----
    for (int i = 0; i < 32; i++) begin drive(1, 0, 0, 16'(16'h0500 + i)); step(); end
    drive(1, 0, 1, 16'hBAD0);  // rejected write concurrent with err_clr
    step();
    chk("t6.ovf_set_wins", 32'(overflow), 32'h1);
    chk_flags("t6.full", 32);
    for (int k = 0; k < 20; k++) begin drive(0, 1, 0, 16'h0); step(); end
    chk_flags("t6.pre", 12);
    chk("t6.pre.dout", 32'(dout), 32'h0513);
    chk("t6.pre.dout_valid", 32'(dout_valid), 32'h1);
    #2 rst = 1'b0;  // mid-cycle, away from any clock edge
    #1;
    chk_flags("t6.rst", 0);
    chk("t6.rst.overflow", 32'(overflow), 32'h0);
    chk("t6.rst.dout", 32'(dout), 32'h0);
    chk("t6.rst.dout_valid", 32'(dout_valid), 32'h0);
    $display("[TB] t6 async reset: cnt=%0d dout=%h ovf=%0b", counter, dout, overflow);
    drive(0, 0, 0, 16'h0);
    step();
    rst = 1'b1;
    drive(1, 0, 0, 16'hBEEF);
    step();
    chk_flags("t6.post_wr", 1);
    drive(0, 1, 0, 16'h0);
    step();
    chk("t6.post_rd.dout", 32'(dout), 32'hBEEF);
    chk("t6.post_rd.dout_valid", 32'(dout_valid), 32'h1);
    chk_flags("t6.post_rd", 0);
    drive(0, 0, 0, 16'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
